subleq_ctrl: RTL and testbench

SUBLEQ_CTRL -- requirements
Module: subleq_ctrl

---
 rtl/subleq_ctrl_if.sv | 22 ++
 rtl/subleq_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_subleq_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/subleq_ctrl_if.sv
// RAM control bus shared between the SUBLEQ controller and its RAM.
//
// Signals:
//   ope - output enable, active-low
//   ctl - 0 = write strobe, 1 = read
//   ena - chip enable, active-low
//   adr - 8-bit RAM address
// The bidirectional data bus stays a plain inout port on the controller so
// that tristate resolution happens on an ordinary net.
//
// Modports:
//   master - controller side, drives every control signal
//   slave  - RAM side, observes every control signal
interface subleq_ctrl_if;
    logic       ope;
    logic       ctl;
    logic       ena;
    logic [7:0] adr;

    modport master (output ope, ctl, ena, adr);
    modport slave  (input  ope, ctl, ena, adr);
endinterface

// File: rtl/subleq_ctrl.sv
// SUBLEQ processor controller driving an asynchronous 8-bit RAM.
//
// Each instruction does the following:
//   A = mem[pc], B = mem[pc+1], C = mem[pc+2]
//   mem[B] = mem[B] - mem[A]
//   if the result is <= 0 (signed), pc = C; otherwise pc = pc + 3
// A taken branch to C = 8'hFF halts the controller until the next reset.
//
// Ports:
//   clk    - sole clock, rising edge
//   rst_n  - synchronous reset, active-low
//   run    - start/continue execution, sampled at instruction boundaries
//   bus    - RAM control (ope/ctl/ena/adr), master side
//   dat    - RAM data bus, driven only in the write states
//   pc     - program counter
//   busy   - high whenever the controller is neither idle nor halted
//   halted - sticky halt flag
//
// Every output comes straight from a flop. The bus control values are
// decoded from the next state and registered together with the state, so
// the outputs always match the current state.
//
// An instruction takes 14 cycles:
//   FA(2) FB(2) FC(2) RA(2) RB(2) WSET(1) WSTB(1) WHLD(1) EXEC(1)
module subleq_ctrl (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    subleq_ctrl_if.master bus,
    inout  wire  [7:0]    dat,
    output logic [7:0]    pc,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [3:0] {
        StIdle,
        StFa,
        StFb,
        StFc,
        StRa,
        StRb,
        StWset,
        StWstb,
        StWhld,
        StExec,
        StHalt
    } state_e;

    state_e     state_q, state_d;
    // High during the second cycle of a two-cycle read.
    logic       phase_q, phase_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] c_q, c_d;
    // mem[A], held until mem[B] arrives.
    logic [7:0] ma_q, ma_d;
    // mem[B] - mem[A]. This is both the write data and the branch operand.
    logic [7:0] wdat_q, wdat_d;
    logic       dat_oe_q, dat_oe_d;
    logic       ope_q, ope_d;
    logic       ctl_q, ctl_d;
    logic       ena_q, ena_d;
    logic [7:0] adr_q, adr_d;
    logic       busy_q, busy_d;
    logic       halted_q, halted_d;

    logic       taken;

    // The branch test uses the wrapped 8-bit result: negative or zero.
    assign taken = wdat_q[7] | (wdat_q == 8'h00);

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        phase_d  = 1'b0;
        pc_d     = pc_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        ma_d     = ma_q;
        wdat_d   = wdat_q;
        halted_d = halted_q;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFa;
                end
            end
            StFa: begin
                if (phase_q) begin
                    a_d     = dat;
                    state_d = StFb;
                end else begin
                    phase_d = 1'b1;
                end
            end
            StFb: begin
                if (phase_q) begin
                    b_d     = dat;
                    state_d = StFc;
                end else begin
                    phase_d = 1'b1;
                end
            end
            StFc: begin
                if (phase_q) begin
                    c_d     = dat;
                    state_d = StRa;
                end else begin
                    phase_d = 1'b1;
                end
            end
            StRa: begin
                if (phase_q) begin
                    ma_d    = dat;
                    state_d = StRb;
                end else begin
                    phase_d = 1'b1;
                end
            end
            StRb: begin
                if (phase_q) begin
                    wdat_d  = dat - ma_q;
                    state_d = StWset;
                end else begin
                    phase_d = 1'b1;
                end
            end
            StWset: state_d = StWstb;
            StWstb: state_d = StWhld;
            StWhld: state_d = StExec;
            StExec: begin
                // The write has already been done. A halt only leaves pc
                // unchanged.
                if (taken && (c_q == 8'hFF)) begin
                    halted_d = 1'b1;
                    state_d  = StHalt;
                end else begin
                    pc_d    = taken ? c_q : pc_q + 8'd3;
                    state_d = run ? StFa : StIdle;
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // Bus controls for the state being entered
    always_comb begin
        ena_d    = 1'b1;
        ope_d    = 1'b1;
        ctl_d    = 1'b1;
        dat_oe_d = 1'b0;
        adr_d    = adr_q;
        busy_d   = (state_d != StIdle) && (state_d != StHalt);

        unique case (state_d)
            StFa: begin
                ena_d = 1'b0;
                ope_d = 1'b0;
                adr_d = pc_d;
            end
            StFb: begin
                ena_d = 1'b0;
                ope_d = 1'b0;
                adr_d = pc_d + 8'd1;
            end
            StFc: begin
                ena_d = 1'b0;
                ope_d = 1'b0;
                adr_d = pc_d + 8'd2;
            end
            StRa: begin
                ena_d = 1'b0;
                ope_d = 1'b0;
                adr_d = a_d;
            end
            StRb: begin
                ena_d = 1'b0;
                ope_d = 1'b0;
                adr_d = b_d;
            end
            StWset, StWhld: begin
                ena_d    = 1'b0;
                adr_d    = b_q;
                dat_oe_d = 1'b1;
            end
            StWstb: begin
                // The RAM commits on this falling ctl edge.
                ena_d    = 1'b0;
                ctl_d    = 1'b0;
                adr_d    = b_q;
                dat_oe_d = 1'b1;
            end
            default: begin
                // The bus is idle in IDLE, EXEC and HALT. adr keeps its last value.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            phase_q  <= 1'b0;
            pc_q     <= 8'h00;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            c_q      <= 8'h00;
            ma_q     <= 8'h00;
            wdat_q   <= 8'h00;
            dat_oe_q <= 1'b0;
            ope_q    <= 1'b1;
            ctl_q    <= 1'b1;
            ena_q    <= 1'b1;
            adr_q    <= 8'h00;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            pc_q     <= pc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            ma_q     <= ma_d;
            wdat_q   <= wdat_d;
            dat_oe_q <= dat_oe_d;
            ope_q    <= ope_d;
            ctl_q    <= ctl_d;
            ena_q    <= ena_d;
            adr_q    <= adr_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign dat     = dat_oe_q ? wdat_q : 8'hzz;
    assign bus.ope = ope_q;
    assign bus.ctl = ctl_q;
    assign bus.ena = ena_q;
    assign bus.adr = adr_q;
    assign pc      = pc_q;
    assign busy    = busy_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_subleq_ctrl.sv
// Testbench for subleq_ctrl.
//
// The bench contains an asynchronous RAM model. The RAM drives dat whenever
// ena = 0 and ope = 0, and it commits a write on the falling edge of ctl.
//
// A reference model works at the instruction level on a separate copy of
// memory and steps once per instruction. After each run the bench compares
// the RAM contents, pc, the halted flag, the cycle count and the number of
// writes against that model.
module tb_subleq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    wire  [7:0] dat;
    logic [7:0] pc;
    logic       busy;
    logic       halted;

    always #5 clk = ~clk;

    subleq_ctrl_if bus_if ();

    subleq_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .bus    (bus_if),
        .dat    (dat),
        .pc     (pc),
        .busy   (busy),
        .halted (halted)
    );

    // RAM model
    logic [7:0] ram [256];
    logic [7:0] img [256];
    logic       load_req = 1'b0;
    logic       ctl_prev = 1'b1;
    int         wr_count = 0;
    int         overlap  = 0;

    assign dat = (!bus_if.ena && !bus_if.ope) ? ram[bus_if.adr] : 8'hzz;

    always @(negedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) ram[i] = img[i];
        end else if (!bus_if.ena && ctl_prev && !bus_if.ctl) begin
            ram[bus_if.adr] = dat;
            wr_count++;
        end
        if (!bus_if.ope && !bus_if.ctl) overlap++;
        ctl_prev = bus_if.ctl;
    end

    // Reference model
    logic [7:0] ref_mem [256];
    logic [7:0] ref_pc;
    logic       ref_halted;

    task automatic ref_step();
        logic [7:0] p1, p2, a, b, c, r;
        p1 = ref_pc + 8'd1;
        p2 = ref_pc + 8'd2;
        a  = ref_mem[ref_pc];
        b  = ref_mem[p1];
        c  = ref_mem[p2];
        r  = ref_mem[b] - ref_mem[a];
        ref_mem[b] = r;
        if ($signed(r) <= 0) begin
            if (c == 8'hFF) ref_halted = 1'b1;
            else            ref_pc = c;
        end else begin
            ref_pc = ref_pc + 8'd3;
        end
    endtask

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
    endtask

    // Reset the DUT, load img into the RAM and into the model.
    task automatic prep();
        run   = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        load_req = 1'b1;
        @(negedge clk); #1;
        load_req = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = img[i];
        ref_pc     = 8'h00;
        ref_halted = 1'b0;
        @(posedge clk); #1;
    endtask

    // Run up to k instructions. run stays high across boundaries and drops
    // once the last instruction has begun.
    task automatic run_n(input int k, input string tag);
        int steps, n, wr0;
        steps = 0;
        for (int i = 0; i < k; i++) begin
            if (!ref_halted) begin
                ref_step();
                steps++;
            end
        end
        wr0 = wr_count;
        run = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (busy && n < 14 * k + 10) begin
            n++;
            if (n >= 14 * (k - 1) + 1) run = 1'b0;
            @(posedge clk); #1;
        end
        run = 1'b0;
        check_eq({tag, "_cycles"}, n, 14 * steps);
        check_eq({tag, "_pc"}, pc, ref_pc);
        check_eq({tag, "_halted"}, halted, ref_halted);
        check_eq({tag, "_writes"}, wr_count - wr0, steps);
        check_eq({tag, "_memdiff"}, mem_diffs(), 0);
        check_eq({tag, "_busidle"}, {bus_if.ena, bus_if.ope, bus_if.ctl}, 3'b111);
    endtask

    initial begin
        int wr0;
        run   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pc", pc, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_halted", halted, 1'b0);
        check_eq("rst_bus", {bus_if.ena, bus_if.ope, bus_if.ctl}, 3'b111);
        check_eq("rst_adr", bus_if.adr, 8'h00);
        rst_n = 1'b1;

        // Taken branch to a negative result
        clear_img();
        img[0] = 8'd10; img[1] = 8'd11; img[2] = 8'd9; img[10] = 8'd3; img[11] = 8'd2;
        prep();
        run_n(1, "r19");
        check_eq("r19_mem11", ram[11], 8'hFF);
        check_eq("r19_pcval", pc, 8'd9);

        // Not taken
        clear_img();
        img[0] = 8'd10; img[1] = 8'd11; img[2] = 8'd9; img[10] = 8'd1; img[11] = 8'd5;
        prep();
        run_n(1, "r20");
        check_eq("r20_mem11", ram[11], 8'd4);
        check_eq("r20_pcval", pc, 8'd3);

        // Overflow wraps to a positive result, so not taken
        clear_img();
        img[0] = 8'd10; img[1] = 8'd11; img[2] = 8'd9; img[10] = 8'd1; img[11] = 8'h80;
        prep();
        run_n(1, "r21");
        check_eq("r21_mem11", ram[11], 8'h7F);
        check_eq("r21_pcval", pc, 8'd3);

        // Halt, then toggle run while halted
        clear_img();
        img[0] = 8'd12; img[1] = 8'd12; img[2] = 8'd255; img[12] = 8'd7;
        prep();
        run_n(1, "r22");
        check_eq("r22_mem12", ram[12], 8'd0);
        wr0 = wr_count;
        for (int i = 0; i < 8; i++) begin
            run = i[0];
            @(posedge clk); #1;
            check_eq("r22_hold", {busy, halted, pc, bus_if.ena, bus_if.ope, bus_if.ctl},
                     {1'b0, 1'b1, 8'h00, 3'b111});
        end
        run = 1'b0;
        check_eq("r22_nowr", wr_count - wr0, 0);

        // Wrap of pc and of the fetch addresses across 255 -> 0
        clear_img();
        img[0] = 8'd20; img[1] = 8'd20; img[2] = 8'd254; img[20] = 8'd0;
        img[254] = 8'd21; img[255] = 8'd22; img[21] = 8'd1; img[22] = 8'd5;
        prep();
        run_n(1, "r23a");
        check_eq("r23_pc1", pc, 8'd254);
        run_n(1, "r23b");
        check_eq("r23_mem22", ram[22], 8'd4);
        check_eq("r23_pc2", pc, 8'd1);

        // Two instructions back to back with run held high
        clear_img();
        img[0] = 8'd10; img[1] = 8'd11; img[2] = 8'd3; img[3] = 8'd10; img[4] = 8'd11;
        img[5] = 8'd0; img[10] = 8'd1; img[11] = 8'd5;
        prep();
        run_n(2, "b2b");

        // Reset during WSTB: the write already committed and is not repeated
        clear_img();
        img[0] = 8'd10; img[1] = 8'd11; img[2] = 8'd9; img[10] = 8'd3; img[11] = 8'd2;
        prep();
        wr0 = wr_count;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        for (int i = 1; i < 12; i++) begin
            @(posedge clk); #1;
        end
        check_eq("r24_wstb_ctl", bus_if.ctl, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("r24_ctl", bus_if.ctl, 1'b1);
        check_eq("r24_pc", pc, 8'h00);
        check_eq("r24_busy", busy, 1'b0);
        check_eq("r24_mem11", ram[11], 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        check_eq("r24_writes", wr_count - wr0, 1);
        check_eq("r24_idle", busy, 1'b0);

        // Random programs
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
            prep();
            run_n($urandom_range(1, 3), "rnd");
        end

        check_eq("ope_ctl_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
